// File: rtl/i2c_target_rx.sv
// Write-only I2C target. It receives bytes addressed to TARGET_ADDR and hands each one
// to a single-entry AXI-Stream slot. When the slot is still occupied, the byte is NACKed.
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       busy_o,
  output logic       overrun_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } state_t;

  state_t     state;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic       bus_armed;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       do_ack;
  logic       ack_second_fall;

  logic       scl_rise, scl_fall, start_det, stop_det, last_bit;
  logic [7:0] byte_in;

  // Synchronizer and delay flops reset high so that an idle bus produces no false edge.
  // START is suppressed until both lines have actually been seen high after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_s1    <= 1'b1;
      scl_s2    <= 1'b1;
      scl_d     <= 1'b1;
      sda_s1    <= 1'b1;
      sda_s2    <= 1'b1;
      sda_d     <= 1'b1;
      bus_armed <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the previous stage's old value,
      // which is what makes this a real shift chain instead of a wire.
      scl_s1    <= scl_i;
      scl_s2    <= scl_s1;
      scl_d     <= scl_s2;
      sda_s1    <= sda_i;
      sda_s2    <= sda_s1;
      sda_d     <= sda_s2;
      bus_armed <= bus_armed | (scl_s1 & sda_s1 & scl_s2 & sda_s2);
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = bus_armed & scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = bus_armed & scl_s2 & scl_d & ~sda_d & sda_s2;
  assign byte_in   = {shreg[6:0], sda_s2};
  assign last_bit  = (bit_cnt == 3'd7);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      shreg           <= 8'h00;
      bit_cnt         <= 3'd0;
      do_ack          <= 1'b0;
      ack_second_fall <= 1'b0;
      sda_oe_o        <= 1'b0;
      m_axis_tdata    <= 8'h00;
      m_axis_tvalid   <= 1'b0;
      busy_o          <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      // The slot is released only by a handshake. A decision in this same cycle still sees it full.
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      if (start_det) begin
        state           <= ST_ADDR;
        bit_cnt         <= 3'd0;
        sda_oe_o        <= 1'b0;
        ack_second_fall <= 1'b0;
        busy_o          <= 1'b1;
      end else if (stop_det) begin
        state           <= ST_IDLE;
        sda_oe_o        <= 1'b0;
        ack_second_fall <= 1'b0;
        busy_o          <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                if (byte_in[7:1] == TARGET_ADDR && !byte_in[0]) begin
                  state  <= ST_ADDR_ACK;
                  do_ack <= 1'b1;
                end else begin
                  state <= ST_IGNORE;
                end
              end
            end
          end

          ST_DATA: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                state <= ST_DATA_ACK;
                if (!m_axis_tvalid) begin
                  m_axis_tdata  <= byte_in;
                  m_axis_tvalid <= 1'b1;
                  do_ack        <= 1'b1;
                end else begin
                  overrun_o <= 1'b1;
                  do_ack    <= 1'b0;
                end
              end
            end
          end

          // The first falling edge starts the 9th clock and the second one ends it.
          // For a NACK, SDA simply stays released for the whole clock.
          ST_ADDR_ACK, ST_DATA_ACK: begin
            if (scl_fall) begin
              if (!ack_second_fall) begin
                ack_second_fall <= 1'b1;
                sda_oe_o        <= do_ack;
              end else begin
                ack_second_fall <= 1'b0;
                sda_oe_o        <= 1'b0;
                bit_cnt         <= 3'd0;
                state           <= ST_DATA;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule
